// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Purpose  : Central pipeline controller for the five-stage core. Arbitrates
//            IF/ID/EX/MEM stall requests, drives the exception flush and
//            redirect PC, sequences the multi-cycle divider and counts stall
//            cycles.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
  parameter int DIV_TIMEOUT = 64,  // max cycles in DIV_BUSY before abort (>=2)
  parameter int CNT_W       = 32   // width of the stall-cycle counter
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             ex_div_start,
  input  logic             div_ready,
  input  logic             stallreq_mem,
  input  logic             exc_req,
  input  logic [31:0]      exc_handler_pc,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             div_start_o,
  output logic             div_cancel,
  output logic             div_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int                  C_BUSY_W   = $clog2(DIV_TIMEOUT + 1);
  localparam logic [C_BUSY_W-1:0] C_BUSY_MAX = C_BUSY_W'(DIV_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DIV_BUSY = 2'd1,
    S_DIV_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [C_BUSY_W-1:0] r_busy_cnt;
  logic [C_BUSY_W-1:0] w_busy_cnt_nxt;
  logic                r_div_timeout;
  logic                w_timeout_set;
  logic [CNT_W-1:0]    r_stall_cycles;
  logic                w_ex_stall;

  // EX holds the pipe while a divide is being launched or is in flight;
  // DIV_DONE releases it so the result can move on.
  assign w_ex_stall = ((r_state == S_IDLE) && ex_div_start) || (r_state == S_DIV_BUSY);

  // Divider FSM state, busy counter and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_busy_cnt    <= '0;
      r_div_timeout <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_busy_cnt <= w_busy_cnt_nxt;
      if (w_timeout_set) begin
        r_div_timeout <= 1'b1;
      end
    end
  end

  // Divider FSM next state and the start/cancel handshake pulses.
  always_comb begin
    w_state_nxt    = r_state;
    w_busy_cnt_nxt = r_busy_cnt;
    w_timeout_set  = 1'b0;
    div_start_o    = 1'b0;
    div_cancel     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A MEM stall or exception blocks the launch; retry next cycle.
        if (ex_div_start && !exc_req && !stallreq_mem) begin
          div_start_o    = 1'b1;
          w_state_nxt    = S_DIV_BUSY;
          w_busy_cnt_nxt = C_BUSY_W'(1);
        end
      end
      S_DIV_BUSY: begin
        if (exc_req) begin
          div_cancel     = 1'b1;
          w_state_nxt    = S_IDLE;
          w_busy_cnt_nxt = '0;
        end else if (div_ready) begin
          w_state_nxt    = S_DIV_DONE;
          w_busy_cnt_nxt = '0;
        end else if (r_busy_cnt == C_BUSY_MAX) begin
          w_timeout_set  = 1'b1;
          div_cancel     = 1'b1;
          w_state_nxt    = S_IDLE;
          w_busy_cnt_nxt = '0;
        end else begin
          w_busy_cnt_nxt = r_busy_cnt + C_BUSY_W'(1);
        end
      end
      S_DIV_DONE: begin
        // ex_div_start is still high for the completing DIV; ignore it.
        if (exc_req || !stallreq_mem) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_busy_cnt_nxt = '0;
      end
    endcase
  end

  // Stall/flush priority decode: exception, MEM, EX, ID, IF.
  always_comb begin
    stall  = 6'b000000;
    flush  = 1'b0;
    new_pc = 32'h0;
    if (exc_req) begin
      flush  = 1'b1;
      new_pc = exc_handler_pc;
    end else if (stallreq_mem) begin
      stall = 6'b011111;
    end else if (w_ex_stall) begin
      stall = 6'b001111;
    end else if (stallreq_id) begin
      stall = 6'b000111;
    end else if (stallreq_if) begin
      stall = 6'b000011;
    end
  end

  // Saturating count of cycles in which the PC is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (stall[0] && (r_stall_cycles != {CNT_W{1'b1}})) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign div_timeout  = r_div_timeout;
  assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire
